// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the memory responder slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_responder_pkg;

  // CPU data bus word
  typedef logic [15:0] reg_bus_t;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // CPU bus direction encoding (ram_we_i): 1 = read, 0 = write
  localparam logic DIR_RD = 1'b1;
  localparam logic DIR_WR = 1'b0;

  // True when any address bit above the memory depth is set
  function automatic logic addr_oor(input logic [15:0] a, input int aw);
    return (a >> aw) != 16'd0;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// CPU access and program-load signals of the memory responder.
// Latency: n/a (wiring only).
// Backpressure: CPU holds ram_req_i until ram_ready_o; loads are never stalled in IDLE.
interface mem_responder_if;
  import mem_responder_pkg::*;

  logic     ram_req_i;
  reg_bus_t ram_addr_i;
  logic     ram_we_i;
  logic     ram_ready_o;
  logic     load_en_i;
  reg_bus_t load_addr_i;
  reg_bus_t load_data_i;
  logic     load_busy_o;
  logic     err_o;

  modport slave (
    input  ram_req_i, ram_addr_i, ram_we_i, load_en_i, load_addr_i, load_data_i,
    output ram_ready_o, load_busy_o, err_o
  );

  modport master (
    output ram_req_i, ram_addr_i, ram_we_i, load_en_i, load_addr_i, load_data_i,
    input  ram_ready_o, load_busy_o, err_o
  );

endinterface

// File: rtl/mem_responder_resp_ram.sv
// Single-port 2**ADDR_W x 16 storage, synchronous write, registered read.
// Latency: read data valid one cycle after an enabled access.
// Backpressure: none; accepts an access every cycle.
module resp_ram
  import mem_responder_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  reg_bus_t          wdata,
  output reg_bus_t          rdata
);

  reg_bus_t mem [2**ADDR_W];

  // Write-or-read on enabled cycles; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Wait-stated CPU memory responder with program-load port and sticky range error.
// Latency: ready pulses WAIT_CYCLES+1 cycles after the sampling edge of ram_req_i.
// Backpressure: CPU holds ram_req_i until ready; a pending load in IDLE defers CPU accesses.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic           clk,
  input  logic           rst,
  mem_responder_if.slave bus,
  inout  wire [15:0]     ram_data_io
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  logic [1:0]        state;
  logic [3:0]        count;
  logic [ADDR_W-1:0] addr_q;
  logic              dir_q;
  logic              oor_q;
  logic              err_q;
  logic              ready_q;
  reg_bus_t          wdata_q;

  logic              load_ok;
  logic              acc_start;
  logic              go_resp;
  logic              load_oor;
  logic              in_oor;
  logic              acc_oor;
  logic              acc_dir;
  logic [ADDR_W-1:0] acc_addr;
  reg_bus_t          acc_wdata;

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  reg_bus_t          ram_wdata;
  reg_bus_t          ram_rdata;

  logic              drive;
  reg_bus_t          rd_word;

  // Loads win over CPU requests in IDLE; the RAM port is shared between them
  assign load_ok   = (state == ST_IDLE) && bus.load_en_i;
  assign acc_start = (state == ST_IDLE) && !bus.load_en_i && bus.ram_req_i;
  assign go_resp   = (acc_start && (WAIT_INIT == 4'd0)) ||
                     ((state == ST_WAIT) && (count <= 4'd1));
  assign load_oor  = addr_oor(bus.load_addr_i, ADDR_W);
  assign in_oor    = addr_oor(bus.ram_addr_i, ADDR_W);

  // With zero wait states the access goes to RAM straight from the bus inputs
  assign acc_addr  = (state == ST_IDLE) ? bus.ram_addr_i[ADDR_W-1:0] : addr_q;
  assign acc_dir   = (state == ST_IDLE) ? bus.ram_we_i : dir_q;
  assign acc_wdata = (state == ST_IDLE) ? reg_bus_t'(ram_data_io) : wdata_q;
  assign acc_oor   = (state == ST_IDLE) ? in_oor : oor_q;

  // RAM is touched only on the edge entering RESP, so an abandoned access never writes
  assign ram_en    = load_ok || go_resp;
  assign ram_we    = load_ok ? !load_oor : ((acc_dir == DIR_WR) && !acc_oor);
  assign ram_addr  = load_ok ? bus.load_addr_i[ADDR_W-1:0] : acc_addr;
  assign ram_wdata = load_ok ? bus.load_data_i : acc_wdata;

  resp_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Access FSM: latch request, count wait states, one RESP cycle, back to IDLE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      count   <= 4'd0;
      addr_q  <= '0;
      dir_q   <= DIR_RD;
      oor_q   <= 1'b0;
      wdata_q <= '0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= go_resp;
      case (state)
        ST_IDLE: begin
          if (acc_start) begin
            addr_q <= bus.ram_addr_i[ADDR_W-1:0];
            dir_q  <= bus.ram_we_i;
            oor_q  <= in_oor;
            if (bus.ram_we_i == DIR_WR) wdata_q <= reg_bus_t'(ram_data_io);
            if (WAIT_INIT == 4'd0) begin
              state <= ST_RESP;
            end else begin
              state <= ST_WAIT;
              count <= WAIT_INIT;
            end
          end
        end
        ST_WAIT: begin
          if (count != 4'd0) count <= count - 4'd1;
          if (count <= 4'd1) state <= ST_RESP;
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Sticky error on any out-of-range load or CPU access, cleared only by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else if ((load_ok && load_oor) || (acc_start && in_oor)) begin
      err_q <= 1'b1;
    end
  end

  // Read data is driven only during RESP; out-of-range reads return zero
  assign drive       = (state == ST_RESP) && (dir_q == DIR_RD);
  assign rd_word     = oor_q ? 16'h0000 : ram_rdata;
  assign ram_data_io = drive ? rd_word : 16'hzzzz;

  assign bus.ram_ready_o = ready_q;
  assign bus.load_busy_o = rst && load_ok;
  assign bus.err_o       = err_q;

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, meaning log2 of internal memory depth (256 words).
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 1, meaning added wait states per access (range 0..15).
REQ-003 The block SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port ram_req_i  in  1  CPU access strobe, held until ram_ready_o.
REQ-006 The block SHALL have port ram_addr_i  in  16  CPU word address.
REQ-007 The block SHALL have port ram_we_i  in  1  direction: 1 = read, 0 = write (CPU bus encoding).
REQ-008 The block SHALL have port ram_data_io  inout  16  shared data bus; CPU drives on write, block drives on read.
REQ-009 The block SHALL have port ram_ready_o  out  1  one-cycle access-complete pulse.
REQ-010 The block SHALL have port load_en_i  in  1  program-load write enable.
REQ-011 The block SHALL have port load_addr_i  in  16  program-load word address.
REQ-012 The block SHALL have port load_data_i  in  16  program-load data.
REQ-013 The block SHALL have port load_busy_o  out  1  high while load_en_i is accepted.
REQ-014 The block SHALL have port err_o  out  1  sticky out-of-range access flag.

Function
REQ-015 The FSM SHALL have states IDLE, WAIT, RESP.
REQ-016 In IDLE with load_en_i=1, the block SHALL write load_data_i to mem[load_addr_i] that edge, assert load_busy_o, stay IDLE, and ignore ram_req_i.
REQ-017 In IDLE with load_en_i=0 and ram_req_i=1, the block SHALL latch addr, we and (if write) ram_data_io, then enter WAIT with count=WAIT_CYCLES, or RESP directly if WAIT_CYCLES=0.
REQ-018 In WAIT, the block SHALL decrement count each cycle and enter RESP on the edge where count reaches 1.
REQ-019 Ready SHALL arrive WAIT_CYCLES+1 cycles after the sampling edge of ram_req_i.
REQ-020 In RESP, ram_ready_o SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-021 For a write, mem SHALL update on the edge entering RESP.
REQ-022 For a read, ram_data_io SHALL carry the registered word during RESP only; at all other times it SHALL be high-Z.
REQ-023 If latched address bits [15:ADDR_W] are nonzero: a read SHALL return 16'h0000, a write SHALL be dropped, and err_o SHALL set and hold until reset.
REQ-024 Loads to out-of-range addresses SHALL be dropped and SHALL set err_o.
REQ-025 Deasserting ram_req_i during WAIT SHALL NOT abort the access; ready still pulses.
REQ-026 If ram_req_i is still high in the cycle after RESP, a new access SHALL start from IDLE, giving back-to-back accesses every WAIT_CYCLES+2 cycles.
REQ-027 load_en_i asserted outside IDLE SHALL be ignored and load_busy_o SHALL stay 0.
REQ-028 The wait counter SHALL be 4 bits and SHALL saturate at 0; it SHALL never wrap.

Reset
REQ-029 On rst=0 the block SHALL asynchronously set the FSM to IDLE, count=0, ram_ready_o=0, load_busy_o=0, err_o=0, and ram_data_io to high-Z.
REQ-030 Reset asserted mid-access SHALL abandon the access with no memory write; memory contents SHALL NOT be cleared.

Structure
REQ-031 FSM state encoding and RD/WR direction constants SHALL live in the shared define.v, alongside RegBus.
REQ-032 Storage SHALL be one sub-module, resp_ram: single-port, synchronous write, registered read, depth 2**ADDR_W x 16.
REQ-033 The FSM, wait counter, tristate control and range check SHALL reside in mem_responder.

Verification
REQ-034 Test: WAIT_CYCLES=2, load 16'hBEEF to 0x0010, then read 0x0010 -> ready pulses 3 cycles after request, ram_data_io=16'hBEEF during RESP, Z otherwise.
REQ-035 Test: write 16'h1234 to 0x0005, then read 0x0005 -> 16'h1234; err_o=0.
REQ-036 Test: read 0x0100 (ADDR_W=8) -> data 16'h0000, err_o=1 and held through later valid accesses.
REQ-037 Test: load_en_i and ram_req_i high together in IDLE -> load completes first, load_busy_o=1; CPU ready follows after load_en_i drops.
REQ-038 Test: ram_req_i held high across 3 reads, WAIT_CYCLES=0 -> ready every 2 cycles; bus never driven when not in RESP.
REQ-039 Test: rst pulsed low during WAIT of write 16'hAAAA to 0x0003 -> outputs reset immediately; mem[0x0003] keeps its prior value.
